// File: rtl/f_npc_pc_if.sv
// f_npc_pc_if: D-stage to fetch-PC bundle.
//   master: hazard unit / D stage drives en, D_pc, D_imm26, npc_op, b_jump, D_rs_data
//   slave : fetch PC block drives F_pc, D_pc8, redirect, F_exc_adel
interface f_npc_pc_if;
  logic        en;
  logic [31:0] D_pc;
  logic [25:0] D_imm26;
  logic [2:0]  npc_op;
  logic        b_jump;
  logic [31:0] D_rs_data;
  logic [31:0] F_pc;
  logic [31:0] D_pc8;
  logic        redirect;
  logic        F_exc_adel;

  modport master (
    output en, D_pc, D_imm26, npc_op, b_jump, D_rs_data,
    input  F_pc, D_pc8, redirect, F_exc_adel
  );

  modport slave (
    input  en, D_pc, D_imm26, npc_op, b_jump, D_rs_data,
    output F_pc, D_pc8, redirect, F_exc_adel
  );
endinterface

// File: rtl/f_npc_pc.sv
// f_npc_pc: fetch-stage program counter and next-PC selector.
// Holds the fetch PC, advances by 4 when enabled, and redirects to
// branch / j / jr targets resolved in D. The delay slot is never squashed.
// Ports:
//   clk   - pipeline clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - f_npc_pc_if.slave (en, D_pc, D_imm26, npc_op, b_jump, D_rs_data in;
//           F_pc, D_pc8, redirect, F_exc_adel out)
// Build option: define PC_ALIGN_CHECK_EN to register a fetch address error
// flag (misaligned or outside [IM_BASE, IM_BASE+IM_SIZE)); otherwise the
// flag is tied to 0.
module f_npc_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_3000
) (
  input logic         clk,
  input logic         reset,
  f_npc_pc_if.slave   bus
);

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_SEQ = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_J   = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;

  logic [W-1:0] pc_q;
  logic [W-1:0] next_pc_c;
  logic [W-1:0] d_pc4_c;
  logic [W-1:0] br_off_c;
  logic         redirect_c;

  // Target arithmetic, all modulo 2^32
  assign d_pc4_c  = bus.D_pc + W'(4);
  assign br_off_c = {{14{bus.D_imm26[15]}}, bus.D_imm26[15:0], 2'b00};

  // Next-PC select; reserved opcodes fall through to sequential
  always_comb begin
    next_pc_c  = pc_q + W'(4);
    redirect_c = 1'b0;
    case (bus.npc_op)
      OP_BR: begin
        if (bus.b_jump) begin
          next_pc_c  = d_pc4_c + br_off_c;
          redirect_c = 1'b1;
        end
      end
      OP_J: begin
        next_pc_c  = {d_pc4_c[31:28], bus.D_imm26, 2'b00};
        redirect_c = 1'b1;
      end
      OP_JR: begin
        next_pc_c  = bus.D_rs_data;
        redirect_c = 1'b1;
      end
      OP_SEQ:  ;
      default: ;
    endcase
  end

  // Fetch PC register; a stall discards the computed target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else if (bus.en) begin
      pc_q <= next_pc_c;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [W:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

  logic adel_q;
  logic bad_c;

  // Compare in 33 bits so a window ending at 2^32 does not wrap
  always_comb begin
    bad_c = 1'b0;
    if (next_pc_c[1:0] != 2'b00)       bad_c = 1'b1;
    if (next_pc_c < IM_BASE)           bad_c = 1'b1;
    if ({1'b0, next_pc_c} >= IM_END)   bad_c = 1'b1;
  end

  // Flag tracks the PC actually loaded; the faulting PC is still loaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adel_q <= 1'b0;
    end else if (bus.en) begin
      adel_q <= bad_c;
    end
  end

  assign bus.F_exc_adel = adel_q;
`else
  logic unused_cfg;
  assign unused_cfg     = ^{IM_BASE, IM_SIZE};
  assign bus.F_exc_adel = 1'b0;
`endif

  assign bus.F_pc     = pc_q;
  assign bus.D_pc8    = bus.D_pc + W'(8);
  assign bus.redirect = redirect_c;

endmodule

// File: doc/f_npc_pc.md
# f_npc_pc

Fetch-stage program counter and next-PC selector for the five-stage MIPS pipeline. It is the consumer of the D-stage branch decision. It holds the architectural fetch PC, advances it by 4 each unstalled cycle, and redirects it to branch, jump or jump-register targets resolved in D. Because resolution happens in D, the instruction already fetched behind a control transfer is its delay slot; this block never squashes it.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, fetch PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_SIZE, 32'h0000_3000, size in bytes of the legal instruction window.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  PC write enable from the hazard unit; 0 = stall (hold).
- D_pc  in  32  PC of the instruction currently in D.
- D_imm26  in  26  instr[25:0] of the D instruction.
- npc_op  in  3  D control: 0 = PC+4, 1 = conditional branch, 2 = j/jal, 3 = jr/jalr; 4–7 reserved.
- b_jump  in  1  D-stage compare result; 1 = branch condition true.
- D_rs_data  in  32  forwarded rs value for jr/jalr.
- F_pc  out  32  current fetch PC (register output).
- D_pc8  out  32  D_pc + 8, the link value for jal/jalr (combinational).
- redirect  out  1  combinational; 1 when the D instruction transfers control this cycle.
- F_exc_adel  out  1  fetch address error flag; see Configuration.

## Operation
- Sequential target, evaluated each cycle from the D inputs:
  - npc_op 1 with b_jump=1: D_pc + 4 + (sign_ext(D_imm26[15:0]) << 2).
  - npc_op 1 with b_jump=0: F_pc + 4.
  - npc_op 2: {(D_pc+4)[31:28], D_imm26, 2'b00}.
  - npc_op 3: D_rs_data, loaded verbatim.
  - npc_op 0 or 4–7: F_pc + 4.
- redirect = (npc_op==1 && b_jump) || npc_op==2 || npc_op==3. b_jump is ignored when npc_op≠1.
- All adds are 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. Negative offsets wrap below D_pc the same way.
- en=0: F_pc holds, F_exc_adel holds, and the computed target is discarded. The stall also holds D, so the same redirect is re-presented when en returns; the block keeps no pending-redirect state.
- The delay slot is never killed. A taken branch at D_pc=A loads a target computed from A+4, while F holds A+4.

## Timing
- reset asserted: F_pc = PC_RESET and F_exc_adel = 0 immediately, without waiting for clk. Both hold until the first rising edge after deassertion.
- Reset deasserted mid-operation: the first edge with en=1 loads the normal next PC from PC_RESET.
- Latency: a redirect presented in cycle N appears on F_pc after edge N+1; one delay slot is fetched in between.
- redirect and D_pc8 are purely combinational and carry no reset value.
- en=0 together with redirect=1: no update. The redirect takes effect on the first edge where en=1.

## Configuration
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - F_exc_adel is registered on every loaded edge. It is set to 1 when the newly loaded PC has bits [1:0]≠0, is below IM_BASE, or is at or above IM_BASE+IM_SIZE.
  - The PC is still loaded with the faulting value, so the exception logic sees the bad address.
- Undefined:
  - F_exc_adel is constant 0 and no range or alignment logic is synthesized.
  - PC behaviour is identical in both builds.

## Test plan
- Reset then 3 edges with en=1 and npc_op=0 → F_pc = 3000, 3004, 3008, 300C. Asserting reset between edges → F_pc = 3000 immediately.
- F_pc=3008, D_pc=3004, npc_op=1, b_jump=1, imm16=16'hFFFE → redirect=1; next F_pc = 3000. Same inputs with b_jump=0 → 300C.
- D_pc=3010, npc_op=2, imm26=26'h0000C10 → F_pc = 0000_3040. D_pc8 = 3018.
- npc_op=3, D_rs_data=3100, en=0 for 2 cycles then 1 → F_pc holds for 2 cycles, then loads 3100.
- F_pc=FFFF_FFFC, npc_op=0 → F_pc = 0000_0000. With PC_ALIGN_CHECK_EN defined → F_exc_adel = 1.
- PC_ALIGN_CHECK_EN defined, npc_op=3, D_rs_data=3102 → F_pc = 3102 and F_exc_adel = 1 on the same edge. Undefined build → F_exc_adel stays 0.
